hub75_receiver: RTL and testbench

HUB75_RECEIVER -- requirements
Module: hub75_receiver

---
 rtl/hub75_receiver.sv | 121 ++++++++++++
 tb/tb_hub75_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hub75_receiver.sv
// HUB75 panel input sniffer: syncs the panel pins into clk, shifts serial RGB on oclk,
// and publishes one row per lat edge with row address, OE on-time and error flags.
module hub75_receiver #(
  parameter int unsigned columns      = 32,
  parameter int unsigned rows         = 8,
  parameter int unsigned ontime_width = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      oclk,
  input  logic                      lat,
  input  logic                      oe,
  input  logic [$clog2(rows)-1:0]   row,
  input  logic [2:0]                din,
  output logic [3*columns-1:0]      line_data,
  output logic [$clog2(rows)-1:0]   line_row,
  output logic                      line_valid,
  output logic [ontime_width-1:0]   on_time,
  output logic                      frame_start,
  output logic                      err_len,
  output logic                      err_oe_lat
);

  localparam int unsigned RowW = $clog2(rows);
  localparam int unsigned CntW = $clog2(columns + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(columns);
  localparam logic [CntW-1:0] CntMax  = CntW'(columns + 1);
  localparam logic [RowW-1:0] RowLast = RowW'(rows - 1);

  logic oclk_s1, oclk_s2, oclk_s3;
  logic lat_s1, lat_s2, lat_s3;
  logic oe_s1, oe_s2;
  logic [RowW-1:0] row_s1, row_s2;
  logic [2:0] din_s1, din_s2;

  logic [3*columns-1:0]    shreg;
  logic [CntW-1:0]         shift_cnt;
  logic [ontime_width-1:0] oe_cnt;
  logic [RowW-1:0]         prev_row;

  logic oclk_rise, lat_rise;

  assign oclk_rise = oclk_s2 & ~oclk_s3;
  assign lat_rise  = lat_s2 & ~lat_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oclk_s1     <= 1'b0;
      oclk_s2     <= 1'b0;
      oclk_s3     <= 1'b0;
      lat_s1      <= 1'b0;
      lat_s2      <= 1'b0;
      lat_s3      <= 1'b0;
      oe_s1       <= 1'b0;
      oe_s2       <= 1'b0;
      row_s1      <= '0;
      row_s2      <= '0;
      din_s1      <= '0;
      din_s2      <= '0;
      shreg       <= '0;
      shift_cnt   <= '0;
      oe_cnt      <= '0;
      // Pretend the last row was the bottom one so the first row-0 line marks a frame.
      prev_row    <= RowLast;
      line_data   <= '0;
      line_row    <= '0;
      on_time     <= '0;
      line_valid  <= 1'b0;
      frame_start <= 1'b0;
      err_len     <= 1'b0;
      err_oe_lat  <= 1'b0;
    end else begin
      oclk_s1 <= oclk;
      oclk_s2 <= oclk_s1;
      oclk_s3 <= oclk_s2;
      lat_s1  <= lat;
      lat_s2  <= lat_s1;
      lat_s3  <= lat_s2;
      oe_s1   <= oe;
      oe_s2   <= oe_s1;
      row_s1  <= row;
      row_s2  <= row_s1;
      din_s1  <= din;
      din_s2  <= din_s1;

      line_valid  <= 1'b0;
      frame_start <= 1'b0;

      if (oe_s2 && (oe_cnt != '1)) begin
        oe_cnt <= oe_cnt + 1'b1;
      end

      // New triples enter at the top so the first one shifted ends up in column 0.
      if (oclk_rise) begin
        shreg <= {din_s2, shreg[3*columns-1:3]};
        if (shift_cnt != CntMax) begin
          shift_cnt <= shift_cnt + 1'b1;
        end
      end

      // Latch wins over a coincident shift: publish the old contents, count the new shift.
      if (lat_rise) begin
        line_data   <= shreg;
        line_row    <= row_s2;
        prev_row    <= row_s2;
        on_time     <= oe_cnt;
        line_valid  <= 1'b1;
        frame_start <= (row_s2 == '0) && (prev_row != '0);
        oe_cnt      <= '0;
        shift_cnt   <= oclk_rise ? CntW'(1) : '0;
        if (shift_cnt != CntFull) begin
          err_len <= 1'b1;
        end
        if (oe_s2) begin
          err_oe_lat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_receiver.sv
// Directed bench for hub75_receiver: drives panel-style shift/latch sequences and checks each
// published line against a queue of expected lines.
module tb_hub75_receiver;

  localparam int unsigned Cols = 32;
  localparam int unsigned Rows = 8;
  localparam int unsigned OtW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic oclk = 1'b0, lat = 1'b0, oe = 1'b0;
  logic [2:0] row = '0;
  logic [2:0] din = '0;
  logic [3*Cols-1:0] line_data;
  logic [2:0] line_row;
  logic line_valid, frame_start, err_len, err_oe_lat;
  logic [OtW-1:0] on_time;

  hub75_receiver #(
    .columns      (Cols),
    .rows         (Rows),
    .ontime_width (OtW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .oclk        (oclk),
    .lat         (lat),
    .oe          (oe),
    .row         (row),
    .din         (din),
    .line_data   (line_data),
    .line_row    (line_row),
    .line_valid  (line_valid),
    .on_time     (on_time),
    .frame_start (frame_start),
    .err_len     (err_len),
    .err_oe_lat  (err_oe_lat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3*Cols-1:0] data;
    logic [2:0]        row;
    logic [OtW-1:0]    on;
    logic              fs;
    logic              el;
    logic              eo;
    logic              chk_data;
    logic              chk_on;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int pushes = 0;
  int lv_seen = 0;
  logic [3*Cols-1:0] exp_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: column k carries k mod 8; otherwise random triples.
  task automatic shift_n(input int n, input int mode, output logic [3*Cols-1:0] exp);
    logic [2:0] t;
    exp = '0;
    for (int k = 0; k < n; k++) begin
      t = (mode == 0) ? 3'(k % 8) : 3'($urandom_range(0, 7));
      if (k < int'(Cols)) exp[3*k +: 3] = t;
      din  = t;
      oclk = 1'b1;
      repeat (4) @(negedge clk);
      oclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic latch(input logic [2:0] r, input logic fs, input logic el, input logic eo,
                       input logic chk_data, input logic [3*Cols-1:0] data,
                       input logic chk_on, input logic [OtW-1:0] on);
    exp_t e;
    e.data = data; e.row = r; e.on = on; e.fs = fs; e.el = el; e.eo = eo;
    e.chk_data = chk_data; e.chk_on = chk_on;
    sb.push_back(e);
    pushes++;
    row = r;
    repeat (3) @(negedge clk);
    lat = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("latency_early", line_valid, 1'b0);
    @(posedge clk);
    #1 check("latency_3clk", line_valid, 1'b1);
    repeat (4) @(negedge clk);
    lat = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && line_valid) begin
      exp_t e;
      lv_seen++;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_line_valid: observed row %0d expected no line", line_row);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_data) check("line_data", line_data, e.data);
        if (e.chk_on) check("on_time", on_time, e.on);
        check("line_row", line_row, e.row);
        check("frame_start", frame_start, e.fs);
        check("err_len", err_len, e.el);
        check("err_oe_lat", err_oe_lat, e.eo);
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_line_data", line_data, '0);
    check("rst_line_row", line_row, '0);
    check("rst_on_time", on_time, '0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_err_oe_lat", err_oe_lat, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic line: column k = k mod 8, row 5
    shift_n(32, 0, exp_data);
    latch(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, exp_data, 1'b1, 16'd0);

    // Exactly 100 clk of OE, dropped before the latch
    oe = 1'b1;
    repeat (100) @(negedge clk);
    oe = 1'b0;
    shift_n(32, 1, exp_data);
    latch(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, exp_data, 1'b1, 16'd100);

    // Short line sets err_len, which then stays set
    shift_n(31, 1, exp_data);
    latch(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, exp_data, 1'b1, 16'd0);
    shift_n(32, 1, exp_data);
    latch(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, exp_data, 1'b1, 16'd0);

    // Rows 0..7 then 0: frame_start on both row-0 lines only
    for (int r = 0; r <= 8; r++) begin
      shift_n(32, 1, exp_data);
      latch(3'(r % 8), (r % 8) == 0, 1'b1, 1'b0, 1'b1, exp_data, 1'b1, 16'd0);
    end

    // OE still high at the latch edge
    oe = 1'b1;
    shift_n(32, 1, exp_data);
    latch(3'd1, 1'b0, 1'b1, 1'b1, 1'b1, exp_data, 1'b0, 16'd0);

    // On-time counter saturates
    repeat (70000) @(negedge clk);
    oe = 1'b0;
    shift_n(32, 1, exp_data);
    latch(3'd2, 1'b0, 1'b1, 1'b1, 1'b1, exp_data, 1'b1, 16'hffff);

    // Reset mid-line discards the partial shift and clears the sticky flags
    shift_n(10, 1, exp_data);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_err_len", err_len, 1'b0);
    check("midrst_err_oe_lat", err_oe_lat, 1'b0);
    check("midrst_line_data", line_data, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    shift_n(32, 1, exp_data);
    latch(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, exp_data, 1'b1, 16'd0);

    repeat (10) @(negedge clk);
    check("line_count", lv_seen, pushes);
    check("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
